// File: rtl/spec_stream_rx_pkg.sv
// Shared constants for the spectrometer stream capture unit: FSM encoding,
// CSR byte offsets and CTRL bit positions.
package spec_stream_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] CSR_CTRL   = 8'h00;
  localparam logic [7:0] CSR_STATUS = 8'h04;
  localparam logic [7:0] CSR_SUM    = 8'h08;

  localparam int CTRL_ARM    = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

endpackage

// File: rtl/spec_stream_rx_buf.sv
// Frame buffer: DEPTH x DW, one write port, one registered read port.
// Shape matches a single-port-write / registered-read SRAM macro.
module spec_stream_rx_buf #(
  parameter int DEPTH = 256,
  parameter int DW    = 16,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [IW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spec_stream_rx.sv
// Spectrometer stream receiver: captures one frame while armed, Wishbone CSRs
// and buffer window. Optional running sample sum under SPEC_STREAM_RX_SUM_EN.
module spec_stream_rx
  import spec_stream_rx_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int DW    = 16,
  parameter int AW    = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  output logic          s_ready,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [AW-1:0] wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          irq_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int B  = IW + 2;
  localparam int CW = IW + 1;

  state_t        r_state, w_next;
  logic [CW-1:0] r_count;
  logic          r_ovf, r_irq_en, r_ready, r_ack, r_rd_buf;
  logic [31:0]   r_csr_dat, w_sum;
  logic [DW-1:0] w_rd;

  logic         w_req, w_is_buf, w_ctrl_wr, w_arm, w_abort, w_beat, w_at_end;
  logic         w_arm_go, w_cap;
  logic [B-1:0] w_off;

  assign w_req     = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_is_buf  = wbs_adr_i[B];
  assign w_off     = wbs_adr_i[B-1:0];
  assign w_ctrl_wr = w_req & wbs_we_i & ~w_is_buf & (w_off == B'(CSR_CTRL)) & wbs_sel_i[0];
  assign w_arm     = w_ctrl_wr & wbs_dat_i[CTRL_ARM];
  assign w_abort   = w_ctrl_wr & wbs_dat_i[CTRL_ABORT];
  assign w_beat    = s_valid & r_ready;
  assign w_at_end  = (r_count == CW'(DEPTH - 1));

  // ABORT takes priority over both ARM and any beat landing in the same cycle.
  always_comb begin
    w_next   = r_state;
    w_arm_go = 1'b0;
    w_cap    = 1'b0;
    if (w_abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: if (w_arm) begin
          w_next   = CAPTURE;
          w_arm_go = 1'b1;
        end
        CAPTURE: if (w_beat) begin
          w_cap = 1'b1;
          if (s_last)        w_next = DONE;
          else if (w_at_end) w_next = DRAIN;
        end
        DRAIN: if (w_beat && s_last) w_next = DONE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_irq_en  <= 1'b0;
      r_ready   <= 1'b0;
      r_ack     <= 1'b0;
      r_rd_buf  <= 1'b0;
      r_csr_dat <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == CAPTURE) || (w_next == DRAIN);
      r_ack   <= w_req;
      if (w_ctrl_wr) r_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      if (w_arm_go) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_cap) begin
        r_count <= r_count + 1'b1;
        if (!s_last && w_at_end) r_ovf <= 1'b1;
      end
      if (w_req) begin
        r_rd_buf <= w_is_buf;
        case (w_off)
          B'(CSR_CTRL):   r_csr_dat <= {29'b0, r_irq_en, 2'b0};
          B'(CSR_STATUS): r_csr_dat <= {16'(r_count), 13'b0, r_ovf, r_state};
          B'(CSR_SUM):    r_csr_dat <= w_sum;
          default:        r_csr_dat <= '0;
        endcase
      end
    end
  end

`ifdef SPEC_STREAM_RX_SUM_EN
  logic [31:0] r_sum;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)      r_sum <= '0;
    else if (w_arm_go) r_sum <= '0;
    else if (w_cap)    r_sum <= r_sum + 32'(s_data);
  end
  assign w_sum = r_sum;
`else
  assign w_sum = '0;
`endif

  spec_stream_rx_buf #(.DEPTH(DEPTH), .DW(DW)) u_buf (
    .i_clk   (wb_clk_i),
    .i_we    (w_cap),
    .i_waddr (r_count[IW-1:0]),
    .i_wdata (s_data),
    .i_raddr (wbs_adr_i[B-1:2]),
    .o_rdata (w_rd)
  );

  assign s_ready   = r_ready;
  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_ack ? (r_rd_buf ? 32'(w_rd) : r_csr_dat) : 32'b0;
  assign irq_o     = r_irq_en & (r_state == DONE);

  logic w_unused;
  assign w_unused = ^{wbs_adr_i[AW-1:B+1], wbs_adr_i[1:0], wbs_dat_i[31:3], wbs_sel_i[3:1]};

endmodule
